spi_sram_master: RTL and testbench

Synchronous SPI mode-0 master for 23LC512/23LC1024-class serial SRAMs. It turns single-word read/write requests from the Turing core into READ (0x03) and WRITE (0x02) byte-sequential transactions on one SPI chip. Address width, word size and SCK divider are parametrised. The block replaces hand-rolled per-RAM shifters; one instance drives the state-table RAM and one drives the tape RAM.

---
 rtl/spi_sram_master.sv | 180 ++++++++++++++++++
 tb/tb_spi_sram_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_master.sv
// spi_sram_master: single-word READ/WRITE SPI mode-0 master for 23LC512/23LC1024-class serial SRAMs.
// Define SPI_SRAM_MODE_INIT_EN to send WRMR 0x40 (sequential mode) after every reset.
module spi_sram_master #(
    parameter int unsigned ADDR_BITS  = 16,
    parameter int unsigned WORD_BYTES = 1,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic                      clk,
    input  logic                      spi_rst,
    input  logic                      req,
    output logic                      ready,
    input  logic                      we,
    input  logic [ADDR_BITS-1:0]      addr,
    input  logic [8*WORD_BYTES-1:0]   wdata,
    output logic [8*WORD_BYTES-1:0]   rdata,
    output logic                      done,
    output logic                      sck,
    output logic                      mosi,
    input  logic                      miso,
    output logic                      cs_n
);

    localparam int unsigned DW    = 8 * WORD_BYTES;
    localparam int unsigned N     = 8 + ADDR_BITS + DW;
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned GAP_W = $clog2(CS_GAP + 1);
    localparam int unsigned BIT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_GAP   = 2'd1,
        ST_IDLE  = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

`ifdef SPI_SRAM_MODE_INIT_EN
    localparam state_t         RST_STATE = ST_INIT;
    localparam logic [N-1:0]   RST_FRAME = N'(16'h0140) << (N - 16);
`else
    localparam state_t         RST_STATE = ST_IDLE;
    localparam logic [N-1:0]   RST_FRAME = '0;
`endif

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;
    logic [N-1:0]       shreg_q, shreg_d;
    logic [DW-1:0]      rx_q, rx_d;
    logic               we_q, we_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [BIT_W-1:0]   last_bit;

    // Next-state and output logic; INIT reuses the SHIFT bit engine with a 16-bit frame.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        shreg_d  = shreg_q;
        rx_d     = rx_q;
        we_d     = we_q;
        div_d    = div_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        last_bit = (state_q == ST_INIT) ? BIT_W'(15) : BIT_W'(N - 1);

        case (state_q)
            ST_INIT, ST_SHIFT: begin
                if (cs_n_q) begin
                    // First cycle after entry: select the chip and present the MSB.
                    cs_n_d = 1'b0;
                    mosi_d = shreg_q[N-1];
                    div_d  = '0;
                    bit_d  = '0;
                end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[DW-2:0], miso};
                    end else begin
                        sck_d   = 1'b0;
                        shreg_d = shreg_q << 1;
                        mosi_d  = shreg_q[N-2];
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == last_bit) begin
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                            gap_d   = '0;
                            state_d = ST_GAP;
                            if (state_q == ST_SHIFT) begin
                                done_d = 1'b1;
                                if (!we_q) begin
                                    rdata_d = rx_q;
                                end
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_IDLE: begin
                // Coming out of reset, IDLE waits out one CS gap before offering ready.
                if (!ready_q) begin
                    if (gap_q == GAP_W'(CS_GAP - 1)) begin
                        ready_d = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else if (req) begin
                    ready_d = 1'b0;
                    we_d    = we;
                    shreg_d = {(we ? 8'h02 : 8'h03), addr, wdata};
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (spi_rst) begin
            state_q <= RST_STATE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            shreg_q <= RST_FRAME;
            rx_q    <= '0;
            we_q    <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            shreg_q <= shreg_d;
            rx_q    <= rx_d;
            we_q    <= we_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sck   = sck_q;
    assign mosi  = mosi_q;
    assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_sram_master.sv
// tb_spi_sram_master: randomized scoreboard bench for spi_sram_master (WORD_BYTES=2, CLK_DIV=2)
// with a behavioural 23LC512 model on the SPI pins and a byte-array reference memory.
module tb_spi_sram_master;

    localparam int unsigned AB   = 16;
    localparam int unsigned WB   = 2;
    localparam int unsigned CD   = 2;
    localparam int unsigned CG   = 2;
    localparam int unsigned DW   = 8 * WB;
    localparam int unsigned N    = 8 + AB + DW;
    localparam int          XFER = 1 + 2 * CD * N;

    logic          clk = 1'b0;
    logic          spi_rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic          miso = 1'b0;
    logic [AB-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ready, done, sck, mosi, cs_n;
    logic [DW-1:0] rdata;

    spi_sram_master #(
        .ADDR_BITS (AB),
        .WORD_BYTES(WB),
        .CLK_DIV   (CD),
        .CS_GAP    (CG)
    ) dut (
        .clk    (clk),
        .spi_rst(spi_rst),
        .req    (req),
        .ready  (ready),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .done   (done),
        .sck    (sck),
        .mosi   (mosi),
        .miso   (miso),
        .cs_n   (cs_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference memory and scoreboard queues
    logic [7:0] ref_mem [0:65535];
    logic [DW-1:0] last_rd = '0;
    typedef struct { int cyc; logic [DW-1:0] rdata; } exp_t;
    exp_t         exp_q[$];
    logic [N-1:0] frame_q[$];
    bit  armed = 0;
    bit  skip_frame = 0;
    int  issued = 0;

    // Behavioural serial SRAM (sequential mode, 16-bit address)
    logic [7:0]  sram [0:65535];
    int          rx_cnt = 0;
    logic [63:0] rx_bits = '0;
    logic [7:0]  cmd = '0;
    logic [15:0] ptr = '0;

    always @(negedge cs_n) begin
        rx_cnt  = 0;
        rx_bits = '0;
        cmd     = '0;
    end

    always @(posedge sck) if (cs_n === 1'b0) begin
        rx_bits = {rx_bits[62:0], mosi};
        rx_cnt++;
        if (rx_cnt == 8) cmd = rx_bits[7:0];
        if (rx_cnt == 24 && (cmd == 8'h02 || cmd == 8'h03)) ptr = rx_bits[15:0];
        if (cmd == 8'h02 && rx_cnt > 24 && (rx_cnt - 24) % 8 == 0) begin
            sram[ptr] = rx_bits[7:0];
            ptr = ptr + 16'd1;
        end
    end

    always @(negedge sck) if (cs_n === 1'b0 && cmd == 8'h03 && rx_cnt >= 24) begin
        int bi;
        logic [7:0] bv;
        bi = (rx_cnt - 24) % 8;
        bv = sram[ptr];
        miso = bv[7 - bi];
        if (bi == 7) ptr = ptr + 16'd1;
    end

    // Frame scoreboard: everything shifted under one cs_n window
    always @(posedge cs_n) if (armed) begin
        logic [N-1:0] f;
        if (skip_frame) begin
            skip_frame = 0;
        end else if (frame_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %0d bits, expected no frame", rx_cnt);
        end else begin
            f = frame_q.pop_front();
            check("mosi_frame", rx_bits[N-1:0], f);
            check("frame_bits", rx_cnt, N);
        end
    end

    // Completion monitor
    always @(negedge clk) if (armed && done === 1'b1) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
        end else begin
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("rdata", rdata, e.rdata);
        end
    end

    // SCK timing monitor
    bit sck_prev = 0, cs_prev = 1;
    int cs_fall_cyc = 0, last_rise = 0, rises = 0, cs_falls = 0;
    always @(negedge clk) if (armed) begin
        if (cs_prev && !cs_n) begin
            cs_fall_cyc = cyc;
            rises = 0;
            cs_falls++;
        end
        if (cs_n) check("sck_idle_low", sck, 1'b0);
        if (!sck_prev && sck) begin
            if (rises == 0) check("first_sck_rise", cyc, cs_fall_cyc + CD);
            else            check("sck_period", cyc - last_rise, 2 * CD);
            last_rise = cyc;
            rises++;
        end
        sck_prev = sck;
        cs_prev  = cs_n;
    end

    // Called at a negedge; returns the accept edge number.
    task automatic accept(input logic w, input logic [AB-1:0] a, input logic [DW-1:0] d,
                          input bit track, output int t);
        int budget = 0;
        logic [AB-1:0] ai;
        while (ready !== 1'b1 && budget < 4 * XFER) begin
            @(negedge clk);
            budget++;
        end
        check("ready_before_req", ready, 1'b1);
        we = w; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t = cyc;
        req = 1'b0;
        issued++;
        check("ready_falls_on_accept", ready, 1'b0);
        check("cs_n_high_at_accept", cs_n, 1'b1);
        if (track) begin
            frame_q.push_back({(w ? 8'h02 : 8'h03), a, d});
            for (int i = 0; i < WB; i++) begin
                ai = a + AB'(i);
                if (w) ref_mem[ai] = d[DW-1-8*i -: 8];
                else   last_rd[DW-1-8*i -: 8] = ref_mem[ai];
            end
            exp_q.push_back('{t + XFER, last_rd});
        end
        @(negedge clk);
        check("cs_n_low_after_accept", cs_n, 1'b0);
    endtask

    task automatic finish_op(input int t);
        int budget = 0;
        while (ready !== 1'b1 && budget < 4 * XFER) begin
            @(negedge clk);
            budget++;
        end
        check("ready_rise_cycle", cyc, t + XFER + CG);
    endtask

    task automatic do_op(input logic w, input logic [AB-1:0] a, input logic [DW-1:0] d);
        int t;
        accept(w, a, d, 1, t);
        finish_op(t);
    endtask

    task automatic wait_ready_after_reset(input int r_edge);
        int budget = 0;
        while (ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("ready_after_reset", cyc, r_edge + CG);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, r_edge, edges, budget, falls0;
        logic [AB-1:0] a, tgt, busy_a;
        logic [DW-1:0] old_word;
        logic prev;
        logic [7:0] b;

        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            ref_mem[i] = b;
            sram[i]    = b;
        end

        spi_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdata", rdata, '0);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_cs_n", cs_n, 1'b1);
        r_edge = cyc;
        spi_rst = 1'b0;
        armed = 1;
        wait_ready_after_reset(r_edge);

        // Directed: word straddling the top of the address space
        do_op(1'b1, 16'hFFFF, 16'hBEEF);
        check("sram_ffff", sram[16'hFFFF], 8'hBE);
        check("sram_0000", sram[16'h0000], 8'hEF);
        do_op(1'b0, 16'hFFFF, 16'h0000);
        do_op(1'b1, 16'h1234, 16'hA55A);
        do_op(1'b0, 16'h1234, 16'h0000);

        // Randomized mix concentrated on a small window for read-after-write hits
        for (int k = 0; k < 20; k++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'h0100 + AB'($urandom_range(0, 15));
            do_op(1'($urandom_range(0, 1)), a, DW'($urandom));
        end

        // Request pulsed while busy must be dropped
        busy_a = 16'h0200;
        accept(1'b1, 16'h0180, 16'h1111, 1, t);
        repeat (20) @(negedge clk);
        req = 1'b1; we = 1'b1; addr = busy_a; wdata = 16'h2222;
        @(negedge clk);
        req = 1'b0;
        finish_op(t);
        falls0 = cs_falls;
        repeat (12) @(negedge clk);
        check("busy_no_second_xfer", cs_falls, falls0);
        check("busy_cs_n_high", cs_n, 1'b1);
        do_op(1'b0, busy_a, 16'h0000);

        // Reset in the middle of a write
        tgt = 16'h0300;
        old_word = {ref_mem[tgt], ref_mem[tgt + 16'd1]};
        skip_frame = 1;
        accept(1'b1, tgt, ~old_word, 0, t);
        edges = 0; budget = 0; prev = sck;
        while (edges < 10 && budget < 200) begin
            @(negedge clk);
            if (sck !== prev) edges++;
            prev = sck;
            budget++;
        end
        check("abort_sck_edges", edges, 10);
        spi_rst = 1'b1;
        @(negedge clk);
        check("abort_cs_n", cs_n, 1'b1);
        check("abort_sck", sck, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_rdata", rdata, '0);
        last_rd = '0;
        repeat (2) @(negedge clk);
        r_edge = cyc;
        spi_rst = 1'b0;
        wait_ready_after_reset(r_edge);
        do_op(1'b0, tgt, 16'h0000);
        check("abort_old_value", last_rd, old_word);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("frames_drained", frame_q.size(), 0);
        check("cs_n_falls", cs_falls, issued);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
